// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between N_REQ upstream requesters, fifo_wr_arbiter and the
// write port of the downstream FIFO. slave = arbiter side, master = surroundings.
interface fifo_wr_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       req_valid_i;
  logic [N_REQ*WIDTH-1:0] req_data_i;
  logic [N_REQ-1:0]       req_ready_o;
  logic                   fifo_full_i;
  logic                   fifo_wr_en_o;
  logic [WIDTH-1:0]       fifo_data_o;
  logic [ID_W-1:0]        grant_id_o;

  modport slave (
    input  req_valid_i,
    input  req_data_i,
    input  fifo_full_i,
    output req_ready_o,
    output fifo_wr_en_o,
    output fifo_data_o,
    output grant_id_o
  );

  modport master (
    output req_valid_i,
    output req_data_i,
    output fifo_full_i,
    input  req_ready_o,
    input  fifo_wr_en_o,
    input  fifo_data_o,
    input  grant_id_o
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: N_REQ valid/ready requesters onto one FIFO write port.
// Optional per-owner burst locking is compiled in with `define FIFO_ARB_BURST_EN.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  fifo_wr_arbiter_if.slave arb
);
  localparam int ID_W = $clog2(N_REQ);
  typedef logic [ID_W-1:0] id_t;

  if (N_REQ < 2 || N_REQ > 16 || MAX_BURST < 1 || MAX_BURST > 255) begin : g_param_check
    $error("fifo_wr_arbiter: parameter out of range");
  end

  function automatic id_t next_id(input id_t id);
    return (id == id_t'(N_REQ - 1)) ? '0 : id + id_t'(1);
  endfunction

  id_t  ptr_q, ptr_d;
  id_t  sel_rr;
  id_t  sel;
  logic hs;

  // First valid requester at or after ptr, wrapping; ptr itself when nobody is valid.
  always_comb begin : rr_scan
    logic          found;
    logic [ID_W:0] idx;
    // NOTE: every output of a combinational block gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    found  = 1'b0;
    idx    = '0;
    sel_rr = ptr_q;
    for (int i = 0; i < N_REQ; i++) begin
      idx = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (idx >= (ID_W+1)'(N_REQ)) idx = idx - (ID_W+1)'(N_REQ);
      if (!found && arb.req_valid_i[idx[ID_W-1:0]]) begin
        found  = 1'b1;
        sel_rr = idx[ID_W-1:0];
      end
    end
  end

  // Reset gates the handshake so nothing is accepted or written while rst_i is high.
  assign hs = arb.req_valid_i[sel] & ~arb.fifo_full_i & ~rst_i;

  always_comb begin : drive_outputs
    arb.req_ready_o      = '0;
    arb.req_ready_o[sel] = ~arb.fifo_full_i & ~rst_i;
    arb.fifo_wr_en_o     = hs;
    arb.fifo_data_o      = arb.req_data_i[int'(sel)*WIDTH +: WIDTH];
    arb.grant_id_o       = sel;
  end

`ifdef FIFO_ARB_BURST_EN
  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_e;

  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST);

  state_e     state_q, state_d;
  id_t        owner_q, owner_d;
  logic [7:0] cnt_q,   cnt_d;

  assign sel = (state_q == LOCK) ? owner_q : sel_rr;

  always_comb begin : next_state
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ARB: begin
        if (hs) begin
          ptr_d = next_id(sel);
          if (MAX_BURST > 1) begin
            state_d = LOCK;
            owner_d = sel;
            cnt_d   = 8'd1;
          end
        end
      end
      LOCK: begin
        // Owner going idle ends the burst even if the FIFO is full in that cycle.
        if (!arb.req_valid_i[owner_q]) begin
          state_d = ARB;
          ptr_d   = next_id(owner_q);
          cnt_d   = '0;
        end else if (hs) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == BURST_LAST) begin
            state_d = ARB;
            ptr_d   = next_id(owner_q);
            cnt_d   = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge value of every other flop regardless of statement order.
    if (rst_i) begin
      state_q <= ARB;
      owner_q <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end
`else
  assign sel = sel_rr;

  always_comb begin : next_ptr
    ptr_d = ptr_q;
    if (hs) ptr_d = next_id(sel);
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge value of every other flop regardless of statement order.
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed + randomized bench for fifo_wr_arbiter (N_REQ=4, WIDTH=8, MAX_BURST=4).
// Burst-lock scenarios are selected when FIFO_ARB_BURST_EN is defined.
module tb_fifo_wr_arbiter;
  localparam int N_REQ     = 4;
  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;

  logic clk_i = 1'b0;
  logic rst_i;

  int n_cmp = 0;
  int n_err = 0;

  fifo_wr_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) arb ();

  fifo_wr_arbiter #(
    .N_REQ    (N_REQ),
    .WIDTH    (WIDTH),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .arb  (arb.slave)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    @(negedge clk_i);
  endtask

  function automatic int exp_sel(input logic [N_REQ-1:0] v, input int p);
    for (int i = 0; i < N_REQ; i++) begin
      if (v[(p + i) % N_REQ]) return (p + i) % N_REQ;
    end
    return p;
  endfunction

  localparam logic [N_REQ*WIDTH-1:0] BASE_DATA = {8'hC3, 8'hC2, 8'hC1, 8'hC0};

  logic [N_REQ*WIDTH-1:0] dbuf;
  logic [N_REQ-1:0]       pend;
  logic [N_REQ-1:0]       hsv;
  int                     seq [N_REQ];
  int                     writes;
  int                     cycles;
  int                     mptr;
  int                     es;
  int                     g;

  initial begin
    rst_i           = 1'b1;
    arb.req_valid_i = '1;
    arb.req_data_i  = BASE_DATA;
    arb.fifo_full_i = 1'b0;

    // Reset with all requesters valid: nothing may be accepted or written.
    cyc();
    settle();
    check("rst_ready", arb.req_ready_o, 4'b0000);
    check("rst_wr_en", arb.fifo_wr_en_o, 1'b0);
    cyc();
    rst_i           = 1'b0;
    arb.req_valid_i = '0;
    settle();
    check("idle_grant", arb.grant_id_o, 0);
    check("idle_ready", arb.req_ready_o, 4'b0001);
    check("idle_wr_en", arb.fifo_wr_en_o, 1'b0);
    cyc();

`ifndef FIFO_ARB_BURST_EN
    // All valid: one write per cycle in order 0,1,2,3,0,...
    arb.req_valid_i = '1;
    for (int i = 0; i < 8; i++) begin
      settle();
      check("rr_grant", arb.grant_id_o, i % 4);
      check("rr_wr_en", arb.fifo_wr_en_o, 1'b1);
      check("rr_data", arb.fifo_data_o, 8'hC0 | (i % 4));
      check("rr_ready", arb.req_ready_o, 4'b0001 << (i % 4));
      cyc();
    end

    // Only requester 2 valid with 0xA5; afterwards the pointer must sit at 3.
    dbuf            = BASE_DATA;
    dbuf[2*WIDTH +: WIDTH] = 8'hA5;
    arb.req_data_i  = dbuf;
    arb.req_valid_i = 4'b0100;
    settle();
    check("solo2_wr_en", arb.fifo_wr_en_o, 1'b1);
    check("solo2_data", arb.fifo_data_o, 8'hA5);
    check("solo2_grant", arb.grant_id_o, 2);
    check("solo2_ready", arb.req_ready_o, 4'b0100);
    cyc();
    arb.req_data_i  = BASE_DATA;
    arb.req_valid_i = '1;
    settle();
    check("ptr_after_2", arb.grant_id_o, 3);
    cyc();

    // FIFO full for 5 cycles with requesters 1 and 3 valid; ptr (0) must not move.
    arb.req_valid_i = 4'b1010;
    arb.fifo_full_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("full_wr_en", arb.fifo_wr_en_o, 1'b0);
      check("full_ready", arb.req_ready_o, 4'b0000);
      check("full_grant", arb.grant_id_o, 1);
      cyc();
    end
    arb.fifo_full_i = 1'b0;
    settle();
    check("unfull_grant", arb.grant_id_o, 1);
    check("unfull_wr_en", arb.fifo_wr_en_o, 1'b1);
    check("unfull_data", arb.fifo_data_o, 8'hC1);
    cyc();
    settle();
    check("unfull_next", arb.grant_id_o, 3);
    cyc();

    // Reset in the middle of traffic returns the pointer to 0.
    arb.req_valid_i = '1;
    cyc();
    rst_i = 1'b1;
    settle();
    check("midrst_ready", arb.req_ready_o, 4'b0000);
    check("midrst_wr_en", arb.fifo_wr_en_o, 1'b0);
    cyc();
    rst_i = 1'b0;
    settle();
    check("postrst_grant", arb.grant_id_o, 0);
    check("postrst_wr_en", arb.fifo_wr_en_o, 1'b1);
    cyc();
`else
    // All valid: 4 beats from 0, then 4 beats from 1.
    arb.req_valid_i = '1;
    for (int i = 0; i < 8; i++) begin
      settle();
      check("burst_grant", arb.grant_id_o, i / 4);
      check("burst_wr_en", arb.fifo_wr_en_o, 1'b1);
      check("burst_data", arb.fifo_data_o, 8'hC0 | (i / 4));
      cyc();
    end
    // Requester 2 locks, writes 2 beats, then drops valid.
    for (int i = 0; i < 2; i++) begin
      settle();
      check("lock2_grant", arb.grant_id_o, 2);
      check("lock2_wr_en", arb.fifo_wr_en_o, 1'b1);
      cyc();
    end
    arb.req_valid_i = 4'b1011;
    settle();
    check("drop_grant", arb.grant_id_o, 2);
    check("drop_wr_en", arb.fifo_wr_en_o, 1'b0);
    check("drop_ready", arb.req_ready_o, 4'b0100);
    cyc();
    settle();
    check("after_drop_grant", arb.grant_id_o, 3);
    check("after_drop_wr_en", arb.fifo_wr_en_o, 1'b1);
    cyc();

    // Now locked on requester 3; reset mid-lock must return to ARB with ptr 0.
    arb.req_valid_i = '1;
    rst_i           = 1'b1;
    settle();
    check("midlock_rst_ready", arb.req_ready_o, 4'b0000);
    check("midlock_rst_wr_en", arb.fifo_wr_en_o, 1'b0);
    cyc();
    rst_i = 1'b0;
    settle();
    check("postrst_grant", arb.grant_id_o, 0);
    check("postrst_wr_en", arb.fifo_wr_en_o, 1'b1);
    cyc();
    settle();
    check("postrst_lock", arb.grant_id_o, 0);
    cyc();
`endif

    // Random valid/full traffic with a per-requester sequence scoreboard.
    rst_i           = 1'b1;
    arb.req_valid_i = '0;
    arb.fifo_full_i = 1'b0;
    cyc();
    rst_i  = 1'b0;
    mptr   = 0;
    writes = 0;
    cycles = 0;
    pend   = '0;
    for (int k = 0; k < N_REQ; k++) seq[k] = 0;

    while (writes < 1000 && cycles < 20000) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (!pend[k] && $urandom_range(0, 2) != 0) pend[k] = 1'b1;
        dbuf[k*WIDTH +: WIDTH] = {2'(k), 6'(seq[k])};
      end
      arb.req_valid_i = pend;
      arb.req_data_i  = dbuf;
      arb.fifo_full_i = ($urandom_range(0, 3) == 0);
      settle();

      hsv = arb.req_ready_o & arb.req_valid_i;
      check("rand_wr_is_hs", arb.fifo_wr_en_o, |hsv);
      check("rand_ready_onehot", ($countones(arb.req_ready_o) <= 1), 1'b1);
      if (arb.fifo_full_i) check("rand_full_no_wr", arb.fifo_wr_en_o, 1'b0);
`ifndef FIFO_ARB_BURST_EN
      es = exp_sel(pend, mptr);
      check("rand_grant", arb.grant_id_o, es);
      check("rand_ready", arb.req_ready_o, arb.fifo_full_i ? 4'b0000 : (4'b0001 << es));
      check("rand_wr_en", arb.fifo_wr_en_o, pend[es] & ~arb.fifo_full_i);
      if (pend[es] && !arb.fifo_full_i) mptr = (es + 1) % N_REQ;
`endif
      if (arb.fifo_wr_en_o) begin
        g = int'(arb.grant_id_o);
        check("rand_data", arb.fifo_data_o, {2'(g), 6'(seq[g])});
      end
      for (int k = 0; k < N_REQ; k++) begin
        if (hsv[k]) begin
          seq[k]  = seq[k] + 1;
          pend[k] = 1'b0;
          writes  = writes + 1;
        end
      end
      cycles++;
      cyc();
    end
    check("rand_write_count", (writes >= 1000), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
